// File: rtl/segment_register_file.sv
// Segment register bank with one-shot override prefix tracking, registered
// physical-address generation and the post-SS-write interrupt inhibit.

module segment_reg #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RST_VAL;
        else if (we) q <= d;
    end
endmodule

module segment_register_file #(
    parameter int                          WIDTH        = 16,
    parameter int                          NUM_SEG      = 4,
    parameter int                          SEL_W        = 2,
    parameter logic [NUM_SEG*WIDTH-1:0]    RESET_VALUES = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000},
    parameter int                          SS_INDEX     = 2,
    localparam int                         ADDR_W       = WIDTH + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [SEL_W-1:0]  rd_sel_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              ovr_set,
    input  logic [SEL_W-1:0]  ovr_sel,
    input  logic              instr_done,
    output logic              ovr_active,
    output logic [SEL_W-1:0]  ovr_seg,
    input  logic              ag_valid,
    input  logic [SEL_W-1:0]  ag_def_sel,
    input  logic [WIDTH-1:0]  ag_offset,
    output logic              pa_valid,
    output logic [ADDR_W-1:0] pa,
    output logic [SEL_W-1:0]  pa_seg_sel,
    output logic              int_inhibit
);
    typedef enum logic {IDLE, ARMED} ovr_state_t;

    logic [NUM_SEG-1:0][WIDTH-1:0] seg;
    ovr_state_t                    state_q, state_d;
    logic [SEL_W-1:0]              ovr_seg_d;
    logic [SEL_W-1:0]              eff_sel;
    logic [WIDTH-1:0]              eff_seg;
    logic                          ss_wr;

    for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
        segment_reg #(
            .WIDTH   (WIDTH),
            .RST_VAL (RESET_VALUES[g*WIDTH +: WIDTH])
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_en && (wr_sel == SEL_W'(g))),
            .d     (wr_data),
            .q     (seg[g])
        );
    end

    // Select-by-compare keeps out-of-range selects at 0 without wide indexing.
    function automatic logic [WIDTH-1:0] seg_rd(input logic [SEL_W-1:0] sel);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SEG; i++)
            if (sel == SEL_W'(i)) r = seg[i];
        return r;
    endfunction

    assign rd_data_a = seg_rd(rd_sel_a);
    assign rd_data_b = seg_rd(rd_sel_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ovr_seg <= '0;
        end else begin
            state_q <= state_d;
            ovr_seg <= ovr_seg_d;
        end
    end

    // A new prefix beats retirement: it belongs to the next instruction.
    always_comb begin
        state_d   = state_q;
        ovr_seg_d = ovr_seg;
        if (ovr_set) begin
            state_d   = ARMED;
            ovr_seg_d = ovr_sel;
        end else if (instr_done && state_q == ARMED) begin
            state_d   = IDLE;
        end
    end

    assign ovr_active = (state_q == ARMED);
    assign eff_sel    = ovr_active ? ovr_seg : ag_def_sel;
    assign eff_seg    = seg_rd(eff_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_valid   <= 1'b0;
            pa         <= '0;
            pa_seg_sel <= '0;
        end else begin
            pa_valid <= ag_valid;
            if (ag_valid) begin
                pa         <= {eff_seg, 4'b0000} + {4'b0000, ag_offset};
                pa_seg_sel <= eff_sel;
            end
        end
    end

    assign ss_wr = wr_en && (wr_sel == SEL_W'(SS_INDEX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          int_inhibit <= 1'b0;
        else if (ss_wr)      int_inhibit <= 1'b1;
        else if (instr_done) int_inhibit <= 1'b0;
    end
endmodule

// File: tb/tb_segment_register_file.sv
// Directed bench for segment_register_file: reset image, writes/reads,
// address generation, override FSM, SS interrupt inhibit and async reset.

module tb_segment_register_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data;
    logic [1:0]  rd_sel_a, rd_sel_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        ovr_set;
    logic [1:0]  ovr_sel;
    logic        instr_done;
    logic        ovr_active;
    logic [1:0]  ovr_seg;
    logic        ag_valid;
    logic [1:0]  ag_def_sel;
    logic [15:0] ag_offset;
    logic        pa_valid;
    logic [19:0] pa;
    logic [1:0]  pa_seg_sel;
    logic        int_inhibit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    segment_register_file dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
        .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b),
        .ovr_set(ovr_set), .ovr_sel(ovr_sel), .instr_done(instr_done),
        .ovr_active(ovr_active), .ovr_seg(ovr_seg),
        .ag_valid(ag_valid), .ag_def_sel(ag_def_sel), .ag_offset(ag_offset),
        .pa_valid(pa_valid), .pa(pa), .pa_seg_sel(pa_seg_sel),
        .int_inhibit(int_inhibit)
    );

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_sel = 0; wr_data = 0;
        ovr_set = 0; ovr_sel = 0; instr_done = 0;
        ag_valid = 0; ag_def_sel = 0; ag_offset = 0;
    endtask

    task automatic test_reset();
        logic [15:0] img [4];
        img = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        idle_inputs();
        rd_sel_a = 0; rd_sel_b = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_sel_a = 2'(i); rd_sel_b = 2'(3 - i);
            #1;
            checks++;
            if (rd_data_a !== img[i]) begin errors++; $display("FAIL reset_rd_a sel %0d got %h want %h", i, rd_data_a, img[i]); end
            checks++;
            if (rd_data_b !== img[3-i]) begin errors++; $display("FAIL reset_rd_b sel %0d got %h want %h", 3 - i, rd_data_b, img[3-i]); end
        end
        checks++;
        if ({ovr_active, ovr_seg, pa_valid, pa, pa_seg_sel, int_inhibit} !== 27'd0) begin
            errors++;
            $display("FAIL reset_ctrl got ovr=%b seg=%0d pav=%b pa=%h pas=%0d inh=%b want all 0",
                     ovr_active, ovr_seg, pa_valid, pa, pa_seg_sel, int_inhibit);
        end
    endtask

    task automatic test_write_ag();
        wr_en = 1; wr_sel = 3; wr_data = 16'h1234; rd_sel_a = 3;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL no_bypass got %h want 0000", rd_data_a); end
        tick();
        checks++;
        if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL write_ds got %h want 1234", rd_data_a); end
        wr_en = 0;
        ag_valid = 1; ag_def_sel = 3; ag_offset = 16'h0005;
        tick();
        checks++;
        if (pa_valid !== 1'b1 || pa !== 20'h12345 || pa_seg_sel !== 2'd3) begin
            errors++; $display("FAIL ag_ds got v=%b pa=%h sel=%0d want 1 12345 3", pa_valid, pa, pa_seg_sel);
        end
        ag_valid = 0; ag_offset = 16'hAAAA;
        tick();
        checks++;
        if (pa_valid !== 1'b0 || pa !== 20'h12345 || pa_seg_sel !== 2'd3) begin
            errors++; $display("FAIL ag_hold got v=%b pa=%h sel=%0d want 0 12345 3", pa_valid, pa, pa_seg_sel);
        end
    endtask

    task automatic test_override();
        wr_en = 1; wr_sel = 0; wr_data = 16'h2000;
        tick();
        wr_en = 0;
        // Request in the prefix cycle still sees the old (idle) state.
        ovr_set = 1; ovr_sel = 0;
        ag_valid = 1; ag_def_sel = 3; ag_offset = 16'h0010;
        tick();
        checks++;
        if (pa !== 20'h12350 || pa_seg_sel !== 2'd3) begin
            errors++; $display("FAIL ovr_same_cycle_ag got pa=%h sel=%0d want 12350 3", pa, pa_seg_sel);
        end
        checks++;
        if (ovr_active !== 1'b1 || ovr_seg !== 2'd0) begin
            errors++; $display("FAIL ovr_armed got act=%b seg=%0d want 1 0", ovr_active, ovr_seg);
        end
        ovr_set = 0;
        tick();
        checks++;
        if (pa !== 20'h20010 || pa_seg_sel !== 2'd0 || pa_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_ag got pa=%h sel=%0d v=%b want 20010 0 1", pa, pa_seg_sel, pa_valid);
        end
        ag_valid = 0; instr_done = 1;
        tick();
        instr_done = 0;
        checks++;
        if (ovr_active !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", ovr_active); end
        ag_valid = 1;
        tick();
        ag_valid = 0;
        checks++;
        if (pa !== 20'h12350 || pa_seg_sel !== 2'd3) begin
            errors++; $display("FAIL post_ovr_ag got pa=%h sel=%0d want 12350 3", pa, pa_seg_sel);
        end
    endtask

    task automatic test_ovr_retire_and_wrap();
        ovr_set = 1; ovr_sel = 1;
        tick();
        ovr_sel = 2; instr_done = 1;
        tick();
        checks++;
        if (ovr_active !== 1'b1 || ovr_seg !== 2'd2) begin
            errors++; $display("FAIL ovr_set_done got act=%b seg=%0d want 1 2", ovr_active, ovr_seg);
        end
        ovr_set = 0;
        tick();
        instr_done = 0;
        checks++;
        if (ovr_active !== 1'b0) begin errors++; $display("FAIL ovr_retire got %b want 0", ovr_active); end
        wr_en = 1; wr_sel = 1; wr_data = 16'hFFFF;
        tick();
        // Back-to-back: wrap case, then a request racing a CS write.
        wr_en = 0; ag_valid = 1; ag_def_sel = 1; ag_offset = 16'h0010;
        tick();
        checks++;
        if (pa !== 20'h00000 || pa_seg_sel !== 2'd1 || pa_valid !== 1'b1) begin
            errors++; $display("FAIL wrap got pa=%h sel=%0d v=%b want 00000 1 1", pa, pa_seg_sel, pa_valid);
        end
        wr_en = 1; wr_sel = 1; wr_data = 16'hABCD; ag_offset = 16'h0020;
        tick();
        wr_en = 0; ag_valid = 0;
        checks++;
        if (pa !== 20'h00010 || pa_valid !== 1'b1) begin
            errors++; $display("FAIL ag_old_seg got pa=%h v=%b want 00010 1", pa, pa_valid);
        end
        rd_sel_b = 1;
        #1;
        checks++;
        if (rd_data_b !== 16'hABCD) begin errors++; $display("FAIL write_cs got %h want abcd", rd_data_b); end
    endtask

    task automatic test_inhibit();
        wr_en = 1; wr_sel = 0; wr_data = 16'h3000;
        tick();
        checks++;
        if (int_inhibit !== 1'b0) begin errors++; $display("FAIL inh_non_ss got %b want 0", int_inhibit); end
        wr_sel = 2; wr_data = 16'h0100;
        tick();
        wr_en = 0;
        checks++;
        if (int_inhibit !== 1'b1) begin errors++; $display("FAIL inh_set got %b want 1", int_inhibit); end
        instr_done = 1;
        tick();
        instr_done = 0;
        checks++;
        if (int_inhibit !== 1'b0) begin errors++; $display("FAIL inh_clear got %b want 0", int_inhibit); end
        wr_en = 1; wr_sel = 2; wr_data = 16'h0200; instr_done = 1;
        tick();
        wr_en = 0; instr_done = 0;
        checks++;
        if (int_inhibit !== 1'b1) begin errors++; $display("FAIL inh_set_wins got %b want 1", int_inhibit); end
        tick();
        checks++;
        if (int_inhibit !== 1'b1) begin errors++; $display("FAIL inh_hold got %b want 1", int_inhibit); end
        instr_done = 1;
        tick();
        instr_done = 0;
        checks++;
        if (int_inhibit !== 1'b0) begin errors++; $display("FAIL inh_clear2 got %b want 0", int_inhibit); end
    endtask

    task automatic test_async_reset();
        ovr_set = 1; ovr_sel = 3;
        wr_en = 1; wr_sel = 2; wr_data = 16'h0500;
        ag_valid = 1; ag_def_sel = 0; ag_offset = 16'h0001;
        tick();
        idle_inputs();
        checks++;
        if (ovr_active !== 1'b1 || int_inhibit !== 1'b1 || pa_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset got ovr=%b inh=%b pav=%b want 1 1 1", ovr_active, int_inhibit, pa_valid);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (ovr_active !== 1'b0 || int_inhibit !== 1'b0 || pa_valid !== 1'b0 || pa !== 20'h0) begin
            errors++; $display("FAIL async_reset got ovr=%b inh=%b pav=%b pa=%h want 0 0 0 0", ovr_active, int_inhibit, pa_valid, pa);
        end
        rd_sel_a = 2; rd_sel_b = 1;
        #1;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_data_b !== 16'hFFFF) begin
            errors++; $display("FAIL async_reset_regs got ss=%h cs=%h want 0000 ffff", rd_data_a, rd_data_b);
        end
        tick();
        rst_n = 1;
        tick();
        checks++;
        if (pa_valid !== 1'b0 || ovr_active !== 1'b0 || int_inhibit !== 1'b0) begin
            errors++; $display("FAIL post_release got pav=%b ovr=%b inh=%b want 0 0 0", pa_valid, ovr_active, int_inhibit);
        end
    endtask

    initial begin
        test_reset();
        test_write_ag();
        test_override();
        test_ovr_retire_and_wrap();
        test_inhibit();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
